// File: rtl/alu_nibble_seq.sv
// Nibble-serial sequencer for a 4-bit combinational ALU: accepts a wide request,
// steps the ALU one nibble per cycle (LSN first) and returns the assembled result.
module alu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_cmd,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic                 req_cin,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_op,
  output logic                 alu_cin,
  input  logic [3:0]           alu_res,
  input  logic                 alu_cout,
  input  logic                 alu_of,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 res_cout,
  output logic                 res_ovf,
  output logic                 res_zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {
    CMD_ADDC, CMD_ADD, CMD_SUB, CMD_AND, CMD_NOR, CMD_XNOR, CMD_NOT, CMD_LSR
  } cmd_t;

  state_t          state_q, state_d;
  cmd_t            cmd_q;
  logic [W-1:0]    a_q, b_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    result_q;
  logic            cout_q, ovf_q, zero_q;

  logic            accept;
  logic            last_nib;
  logic [3:0]      a_nib, b_nib;
  logic [W-1:0]    a_shr;
  logic [3:0]      res_nib;
  logic [W-1:0]    result_wr;
  logic            carry_init;

  assign accept   = (state_q == IDLE) && req_valid;
  assign last_nib = (idx_q == IW'(NIBBLES - 1));
  assign a_nib    = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib    = b_q[{idx_q, 2'b00} +: 4];
  // Bit 4*idx+3 of A>>1 is A[4*idx+4], and the top bit is already 0.
  assign a_shr    = a_q >> 1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d   = state_q;
    req_ready = 1'b0;
    res_valid = 1'b0;
    alu_a     = 4'h0;
    alu_b     = 4'h0;
    alu_op    = 4'b0000;
    alu_cin   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = RUN;
      end
      RUN: begin
        alu_a = a_nib;
        unique case (cmd_q)
          CMD_ADDC, CMD_ADD: begin alu_op = 4'b0001; alu_b = b_nib;  alu_cin = carry_q; end
          CMD_SUB:           begin alu_op = 4'b0001; alu_b = ~b_nib; alu_cin = carry_q; end
          CMD_AND:           begin alu_op = 4'b0100; alu_b = b_nib; end
          CMD_NOR:           begin alu_op = 4'b0101; alu_b = b_nib; end
          CMD_XNOR:          begin alu_op = 4'b0110; alu_b = b_nib; end
          CMD_NOT:           alu_op = 4'b0111;
          CMD_LSR:           alu_op = 4'b1000;
          default:           alu_op = 4'b0000;
        endcase
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_nib = alu_res;
    if (cmd_q == CMD_LSR) res_nib[3] = a_shr[{idx_q, 2'b11}];
    result_wr = result_q;
    result_wr[{idx_q, 2'b00} +: 4] = res_nib;
  end

  always_comb begin
    unique case (cmd_t'(req_cmd))
      CMD_ADDC: carry_init = req_cin;
      CMD_SUB:  carry_init = 1'b1;
      default:  carry_init = 1'b0;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: operand/command latches carry no reset; they are only read in RUN, after a load.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q <= cmd_t'(req_cmd);
      a_q   <= req_a;
      b_q   <= req_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      carry_q <= carry_init;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      result_q <= result_wr;
      carry_q  <= alu_cout;
      idx_q    <= last_nib ? '0 : idx_q + 1'b1;
      if (last_nib) begin
        cout_q <= (cmd_q <= CMD_SUB) ? alu_cout : 1'b0;
        ovf_q  <= (cmd_q <= CMD_SUB) ? alu_of   : 1'b0;
        zero_q <= (result_wr == '0);
      end
    end
  end

  assign result   = result_q;
  assign res_cout = cout_q;
  assign res_ovf  = ovf_q;
  assign res_zero = zero_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: a behavioural 4-bit ALU closes the loop,
// a full-width reference model feeds a scoreboard queue checked on each result.
module tb_alu_nibble_seq;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready;
  logic [2:0]   req_cmd;
  logic [W-1:0] req_a, req_b;
  logic         req_cin;
  logic [3:0]   alu_a, alu_b, alu_op, alu_res;
  logic         alu_cin, alu_cout, alu_of;
  logic         res_valid, res_ready;
  logic [W-1:0] result;
  logic         res_cout, res_ovf, res_zero;

  alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_of(alu_of),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .res_cout(res_cout), .res_ovf(res_ovf), .res_zero(res_zero)
  );

  always #5 clk = ~clk;

  // Downstream 4-bit ALU.
  always_comb begin
    logic [4:0] s;
    s        = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
    alu_res  = 4'h0;
    alu_cout = 1'b0;
    alu_of   = 1'b0;
    case (alu_op)
      4'b0001: begin
        alu_res  = s[3:0];
        alu_cout = s[4];
        alu_of   = (alu_a[3] == alu_b[3]) && (s[3] != alu_a[3]);
      end
      4'b0100: alu_res = alu_a & alu_b;
      4'b0101: alu_res = ~(alu_a | alu_b);
      4'b0110: alu_res = ~(alu_a ^ alu_b);
      4'b0111: alu_res = ~alu_a;
      4'b1000: alu_res = alu_a >> 1;
      default: alu_res = 4'h0;
    endcase
  end

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [3:0] op_log [8];
  logic       cin_log[8];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic exp_t model(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin);
    exp_t       e;
    logic [W:0] s;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    case (cmd)
      3'd0, 3'd1: begin
        s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (cmd == 3'd0) ? cin : 1'b0};
        e.res  = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'd2: begin
        e.res  = a - b;
        e.cout = (a >= b);
        e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'd3:    e.res = a & b;
      3'd4:    e.res = ~(a | b);
      3'd5:    e.res = ~(a ^ b);
      3'd6:    e.res = ~a;
      default: e.res = a >> 1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, output int waited);
    waited    = 0;
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb.push_back(model(cmd, a, b, cin));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_cmd   = 3'($urandom);
    req_a     = W'($urandom);
    req_b     = W'($urandom);
    req_cin   = 1'($urandom);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!res_valid && n < 50) begin
      if (n < 8) begin
        op_log[n]  = alu_op;
        cin_log[n] = alu_cin;
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(NIBBLES));
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_result"}, 32'(result), 32'(e.res));
    check({tag, "_cout"}, 32'(res_cout), 32'(e.cout));
    check({tag, "_ovf"}, 32'(res_ovf), 32'(e.ovf));
    check({tag, "_zero"}, 32'(res_zero), 32'(e.zero));
  endtask

  task automatic release_res(input string tag);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
  endtask

  task automatic txn(input string tag, input logic [2:0] cmd, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic cin);
    int waited;
    send(cmd, a, b, cin, waited);
    wait_valid(tag);
    check({tag, "_done_alu_op"}, 32'(alu_op), 32'd0);
    check_pop(tag);
    release_res(tag);
  endtask

  initial begin
    int waited;
    logic exp_cin[4];
    exp_cin = '{1'b0, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_a = '0; req_b = '0;
    req_cin = 1'b0; res_ready = 1'b0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, res_cout, res_ovf, res_zero}, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Carry ripple across nibbles, with per-cycle ALU drive.
    txn("add", 3'd1, 16'h00FF, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("add_op%0d", i), 32'(op_log[i]), 32'd1);
      check($sformatf("add_cin%0d", i), 32'(cin_log[i]), 32'(exp_cin[i]));
    end

    txn("sub_neg", 3'd2, 16'h0003, 16'h0005, 1'b0);
    txn("sub_ovf", 3'd2, 16'h8000, 16'h0001, 1'b0);
    txn("addc_zero", 3'd0, 16'hFFFF, 16'h0000, 1'b1);
    txn("xnor", 3'd5, 16'h0F0F, 16'h0F0F, 1'b0);
    txn("lsr", 3'd7, 16'h8421, 16'h0000, 1'b0);
    txn("not", 3'd6, 16'h1234, 16'hFFFF, 1'b0);
    txn("and", 3'd3, 16'hF0F0, 16'h3C3C, 1'b0);
    txn("nor", 3'd4, 16'hA000, 16'h0005, 1'b0);
    for (int i = 0; i < 4; i++)
      txn($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom));

    // Backpressure: result held while a second request waits.
    send(3'd1, 16'h7FFF, 16'h0001, 1'b0, waited);
    wait_valid("bp");
    req_valid = 1'b1; req_cmd = 3'd3; req_a = 16'hF0F0; req_b = 16'h3C3C; req_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), 32'(res_valid), 32'd1);
      check($sformatf("bp_hold_ready%0d", i), 32'(req_ready), 32'd0);
      check($sformatf("bp_hold_result%0d", i), 32'(result), 32'h8000);
    end
    check_pop("bp");
    release_res("bp");
    check("bp_req_ready", 32'(req_ready), 32'd1);
    send(3'd3, 16'hF0F0, 16'h3C3C, 1'b0, waited);
    check("bp_accept_next_edge", 32'(waited), 32'd0);
    wait_valid("bp2");
    check_pop("bp2");
    release_res("bp2");

    // Reset in the middle of RUN.
    send(3'd1, 16'h1234, 16'h1111, 1'b0, waited);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_flags", {29'd0, res_cout, res_ovf, res_zero}, 32'd0);
    check("mid_rst_alu", {19'd0, alu_op, alu_a, alu_b, alu_cin}, 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_no_valid%0d", i), 32'(res_valid), 32'd0);
    end
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    txn("post_rst", 3'd2, 16'h1000, 16'h0001, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
Sequencer directly upstream of the 4-bit combinational ALU. It accepts a NIBBLES×4-bit operation request over a valid/ready handshake and drives the ALU one nibble per cycle, least-significant nibble first. It chains carry between nibbles and captures each ALU result nibble into a wide result register. It presents the full result and flags downstream over a second valid/ready handshake.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (must be ≥1); operand width W = 4*NIBBLES (localparam)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept (IDLE only)
req_cmd  in  3  0 ADD(cin_in), 1 ADD(no cin), 2 SUB, 3 AND, 4 NOR, 5 XNOR, 6 NOT A, 7 LSR A
req_a  in  W  operand A
req_b  in  W  operand B
req_cin  in  1  carry-in for cmd 0
alu_a  out  4  ALU aluin_a
alu_b  out  4  ALU aluin_b
alu_op  out  4  ALU OPCODE
alu_cin  out  1  ALU Cin
alu_res  in  4  ALU alu_out
alu_cout  in  1  ALU Cout
alu_of  in  1  ALU OF
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
result  out  W  full result
res_cout  out  1  final carry (arith only)
res_ovf  out  1  signed overflow (arith only)
res_zero  out  1  result == 0

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset values: state IDLE, req_ready=1, res_valid=0, result=0, res_cout=0, res_ovf=0, res_zero=0, nibble index=0, carry=0.
- While in IDLE or DONE, alu_a, alu_b and alu_cin are 0 and alu_op is 4'b0000.
- FSM states are IDLE, RUN and DONE.
- IDLE: req_ready=1. If req_valid=1, the handshake completes at the clock edge. On that edge, latch req_cmd, req_a and req_b. Initialise carry: cmd0=req_cin, cmd1=0, cmd2=1, others 0. Set idx=0 and go to RUN. Input changes after the handshake are ignored.
- RUN: req_ready=0. ALU inputs are driven combinationally from the latched operands at nibble idx.
  - cmd 0/1: alu_op=0001, alu_b=B[idx], alu_cin=carry.
  - cmd 2 (SUB): alu_op=0001, alu_b=~B[idx], alu_cin=carry. This is A+~B+1; ALU opcode 0011 is never used.
  - cmd 3/4/5/6: alu_op=0100/0101/0110/0111 respectively, alu_cin=0.
  - cmd 7: alu_op=1000.
- RUN, each edge:
  - Write alu_res into result[4*idx+3:4*idx].
  - For cmd 7, bit 4*idx+3 instead takes A[4*idx+4] (0 for the top nibble).
  - carry <= alu_cout. idx increments.
  - On the edge where idx=NIBBLES-1:
    - If cmd≤2: res_cout <= alu_cout and res_ovf <= alu_of (top-nibble values); otherwise both <= 0.
    - res_zero <= 1 if the final full result, including the nibble being written, is 0.
    - Go to DONE.
- Latency: request accepted at edge k produces res_valid=1 after edge k+NIBBLES.
- DONE: res_valid=1; result and flags held stable. req_ready=0, so req_valid is ignored. When res_ready=1 at an edge, go to IDLE and res_valid drops. A new request can be accepted no earlier than the following edge.
- SUB flags: res_cout=1 means no borrow (A≥B unsigned). res_ovf is two's-complement overflow of A−B.
- result is not cleared on return to IDLE; it holds its last value until overwritten.
- rst_n asserted at any time, including mid-RUN or in DONE, immediately forces the reset values. The partial result is discarded and no res_valid is produced for the aborted request.
- NIBBLES=1: a single RUN cycle; the LSR top bit is 0.

Test Plan:
1. ADD no cin, A=0x00FF, B=0x0001 -> res_valid exactly 4 cycles after accept; result=0x0100, cout=0, ovf=0, zero=0. alu_op=0001 on all 4 RUN cycles; alu_cin sequence 0,1,1,0.
2. SUB A=0x0003, B=0x0005 -> result=0xFFFE, cout=0, ovf=0. SUB A=0x8000, B=0x0001 -> result=0x7FFF, cout=1, ovf=1.
3. ADD cin=1, A=0xFFFF, B=0x0000 -> result=0x0000, cout=1, ovf=0, zero=1. XNOR A=0x0F0F, B=0x0F0F -> result=0xFFFF, cout=0, ovf=0.
4. LSR A=0x8421 -> result=0x4210 (cross-nibble bits carried). NOT A=0x1234 -> result=0xEDCB.
5. Backpressure: hold res_ready=0 for 5 cycles while req_valid=1 with new operands -> result and flags stable, req_ready=0, second request not taken. Raise res_ready -> IDLE; second request accepted on the next edge and its result correct.
6. Assert rst_n=0 after the 2nd RUN edge of an ADD -> all outputs at reset values immediately. After release: req_ready=1, no spurious res_valid; a fresh request completes correctly.
